// File: rtl/ks_seq_pkg.sv
// Shared constants for the Karplus-Strong note sequencer.
// Holds the FSM state encodings, the default step-entry field widths and the
// rest-period and minimum-duration constants used by ks_note_sequencer.
package ks_seq_pkg;

    // FSM state encodings; kept as plain constants for older tools.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_PLUCK = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // Default step-entry geometry: field width (period/duration/dyn/tempo)
    // and table depth.
    localparam int SEQ_DATA_W = 8;
    localparam int SEQ_STEPS  = 8;

    // A period of zero marks a rest step (no pluck, period_o untouched).
    localparam int REST_PERIOD = 0;
    // A stored duration of zero still plays for one tick.
    localparam int MIN_DUR = 1;

endpackage

// File: rtl/ks_seq_tick_gen.sv
// Tempo prescaler: one-cycle tick every tempo_i+1 clocks while active_i is high.
// Latency: tick_o is combinational from the internal counter, first tick after tempo_i+1 active cycles.
// Backpressure: none; clear_i restarts the count, an inactive cycle freezes it.
//
// Ports: clk_i/rst_i (clock, async active-high reset), clear_i (restart count),
// active_i (count enable), tempo_i (tick period minus one), tick_o (tick strobe).
module ks_seq_tick_gen #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  active_i,
    input  logic [DATA_WIDTH-1:0] tempo_i,
    output logic                  tick_o
);

    logic [DATA_WIDTH-1:0] cnt;

    assign tick_o = active_i && (cnt == tempo_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (clear_i) begin
            cnt <= '0;
        end else if (active_i) begin
            cnt <= tick_o ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ks_note_sequencer.sv
// Autonomous step sequencer feeding period/pluck (and optional dynamics) to ks_string.
// Latency: per step 1 (LOAD) + PLUCK_CYCLES + max(dur,1)*(tempo+1) clocks; all outputs registered.
// Backpressure: none; enable_i low aborts to IDLE on the next edge, table writes accepted every cycle.
//
// Ports: clk_i/rst_i (KS sample clock, async active-high reset); enable_i, loop_en_i,
// last_step_i, tempo_i (control); wr_en_i/wr_addr_i/wr_period_i/wr_dur_i/wr_dyn_i
// (table write); period_o, pluck_o, dynamics_o (to ks_string); step_o, busy_o, done_o (status).
// Optional feature macro: KS_SEQ_DYNAMICS_EN adds a per-step dynamics field.
module ks_note_sequencer
    import ks_seq_pkg::*;
#(
    parameter int NUM_STEPS    = SEQ_STEPS,
    parameter int DATA_WIDTH   = SEQ_DATA_W,
    parameter int PLUCK_CYCLES = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic                         loop_en_i,
    input  logic [$clog2(NUM_STEPS)-1:0] last_step_i,
    input  logic [DATA_WIDTH-1:0]        tempo_i,
    input  logic                         wr_en_i,
    input  logic [$clog2(NUM_STEPS)-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0]        wr_period_i,
    input  logic [DATA_WIDTH-1:0]        wr_dur_i,
    input  logic [DATA_WIDTH-1:0]        wr_dyn_i,
    output logic [DATA_WIDTH-1:0]        period_o,
    output logic                         pluck_o,
    output logic [DATA_WIDTH-1:0]        dynamics_o,
    output logic [$clog2(NUM_STEPS)-1:0] step_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int CYC_W = $clog2(PLUCK_CYCLES + 1);

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] tbl_period [NUM_STEPS];
    logic [DATA_WIDTH-1:0] tbl_dur    [NUM_STEPS];

    logic [DATA_WIDTH-1:0] cur_dur;   // effective duration of the playing step
    logic [DATA_WIDTH-1:0] tempo_q;   // tempo frozen for the playing step
    logic [DATA_WIDTH-1:0] tick_cnt;
    logic [CYC_W-1:0]      cyc_cnt;
    logic                  tick;

    logic [DATA_WIDTH-1:0] rd_period;
    logic [DATA_WIDTH-1:0] rd_dur;
    logic                  rd_rest;
    logic                  step_last;
    logic                  hold_end;

    assign rd_period = tbl_period[step_o];
    assign rd_dur    = tbl_dur[step_o];
    assign rd_rest   = (rd_period == DATA_WIDTH'(REST_PERIOD));
    // >= so that lowering last_step_i below the playing step ends the run here.
    assign step_last = (step_o >= last_step_i);
    assign hold_end  = tick && (tick_cnt == cur_dur - DATA_WIDTH'(MIN_DUR));

    ks_seq_tick_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tick_gen (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (state == ST_LOAD),
        .active_i (state == ST_HOLD),
        .tempo_i  (tempo_q),
        .tick_o   (tick)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            step_o   <= '0;
            period_o <= '0;
            pluck_o  <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            cur_dur  <= DATA_WIDTH'(MIN_DUR);
            tempo_q  <= '0;
            tick_cnt <= '0;
            cyc_cnt  <= '0;
            for (int i = 0; i < NUM_STEPS; i++) begin
                tbl_period[i] <= '0;
                tbl_dur[i]    <= '0;
            end
        end else begin
            done_o <= 1'b0;

            // Writes land at this edge; a LOAD at the same edge still sees the old entry.
            if (wr_en_i) begin
                tbl_period[wr_addr_i] <= wr_period_i;
                tbl_dur[wr_addr_i]    <= wr_dur_i;
            end

            if (!enable_i) begin
                state   <= ST_IDLE;
                busy_o  <= 1'b0;
                pluck_o <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state  <= ST_LOAD;
                        busy_o <= 1'b1;
                        step_o <= '0;
                    end
                    ST_LOAD: begin
                        // Rest steps keep the previous period so the string is not disturbed.
                        if (!rd_rest) begin
                            period_o <= rd_period;
                            pluck_o  <= 1'b1;
                        end
                        cur_dur  <= (rd_dur == '0) ? DATA_WIDTH'(MIN_DUR) : rd_dur;
                        tempo_q  <= tempo_i;
                        cyc_cnt  <= '0;
                        tick_cnt <= '0;
                        state    <= ST_PLUCK;
                    end
                    ST_PLUCK: begin
                        if (cyc_cnt == CYC_W'(PLUCK_CYCLES - 1)) begin
                            pluck_o <= 1'b0;
                            state   <= ST_HOLD;
                        end else begin
                            cyc_cnt <= cyc_cnt + 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (hold_end) begin
                            if (!step_last) begin
                                step_o <= step_o + 1'b1;
                                state  <= ST_LOAD;
                            end else if (loop_en_i) begin
                                step_o <= '0;
                                state  <= ST_LOAD;
                            end else begin
                                state  <= ST_IDLE;
                                busy_o <= 1'b0;
                                done_o <= 1'b1;
                            end
                        end else if (tick) begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef KS_SEQ_DYNAMICS_EN
    logic [DATA_WIDTH-1:0] tbl_dyn [NUM_STEPS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dynamics_o <= '0;
            for (int i = 0; i < NUM_STEPS; i++) begin
                tbl_dyn[i] <= '0;
            end
        end else begin
            if (wr_en_i) begin
                tbl_dyn[wr_addr_i] <= wr_dyn_i;
            end
            if (enable_i && (state == ST_LOAD) && !rd_rest) begin
                dynamics_o <= tbl_dyn[step_o];
            end
        end
    end
`else
    assign dynamics_o = '0;

    logic unused_dyn;
    assign unused_dyn = ^wr_dyn_i;
`endif

endmodule

// File: tb/tb_ks_note_sequencer.sv
// Directed bench for ks_note_sequencer: single-step vector table plus multi-step sequences.
// Latency: samples outputs on the falling clock edge, drives inputs right after it.
// Backpressure: not applicable; every wait is bounded by a cycle budget.
module tb_ks_note_sequencer;

`ifdef KS_SEQ_DYNAMICS_EN
    localparam bit DYN_EN = 1'b1;
`else
    localparam bit DYN_EN = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       enable_i = 1'b0;
    logic       loop_en_i = 1'b0;
    logic [2:0] last_step_i = '0;
    logic [7:0] tempo_i = '0;
    logic       wr_en_i = 1'b0;
    logic [2:0] wr_addr_i = '0;
    logic [7:0] wr_period_i = '0;
    logic [7:0] wr_dur_i = '0;
    logic [7:0] wr_dyn_i = '0;
    logic [7:0] period_o;
    logic       pluck_o;
    logic [7:0] dynamics_o;
    logic [2:0] step_o;
    logic       busy_o;
    logic       done_o;

    ks_note_sequencer #(
        .NUM_STEPS    (8),
        .DATA_WIDTH   (8),
        .PLUCK_CYCLES (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .enable_i    (enable_i),
        .loop_en_i   (loop_en_i),
        .last_step_i (last_step_i),
        .tempo_i     (tempo_i),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_period_i (wr_period_i),
        .wr_dur_i    (wr_dur_i),
        .wr_dyn_i    (wr_dyn_i),
        .period_o    (period_o),
        .pluck_o     (pluck_o),
        .dynamics_o  (dynamics_o),
        .step_o      (step_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] period;
        logic [2:0] step;
        logic       pluck;
        logic       busy;
        logic       done;
        logic [7:0] dyn;
    } sample_t;

    typedef struct {
        logic [7:0] period;
        logic [7:0] dur;
        logic [7:0] tempo;
        logic [7:0] dyn;
        int         exp_len;     // busy cycles: LOAD + PLUCK + HOLD
        int         exp_plucks;  // cycles with pluck_o high
        logic [7:0] exp_period;
        logic [7:0] exp_dyn;     // with dynamics storage enabled
    } vec_t;

    int checks = 0;
    int errors = 0;
    sample_t tr [0:79];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic sample_t smp();
        sample_t s;
        s.period = period_o;
        s.step   = step_o;
        s.pluck  = pluck_o;
        s.busy   = busy_o;
        s.done   = done_o;
        s.dyn    = dynamics_o;
        return s;
    endfunction

    // Called right after a falling edge; the write is seen at the next rising edge.
    task automatic wr(input logic [2:0] a, input logic [7:0] p, input logic [7:0] d, input logic [7:0] y);
        wr_en_i = 1'b1; wr_addr_i = a; wr_period_i = p; wr_dur_i = d; wr_dyn_i = y;
        @(negedge clk_i);
        wr_en_i = 1'b0;
    endtask

    // Start from IDLE and record n cycles; tr[0] is the LOAD cycle.
    task automatic capture(input int n);
        enable_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            tr[i] = smp();
        end
    endtask

    task automatic go_idle(input int n);
        enable_i = 1'b0;
        repeat (n) @(negedge clk_i);
    endtask

    function automatic int pluck_rises(input int n);
        int c = 0;
        for (int i = 0; i < n; i++)
            if (tr[i].pluck && (i == 0 || !tr[i-1].pluck)) c++;
        return c;
    endfunction

    function automatic int done_count(input int n);
        int c = 0;
        for (int i = 0; i < n; i++)
            if (tr[i].done) c++;
        return c;
    endfunction

    vec_t vec [6];

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        sample_t s;
        int busy_cyc, pl_cyc;
        bit seen;
        int dc;

        vec[0] = '{8'd0,   8'd0, 8'd0, 8'h11,  6, 0, 8'd0,   8'h00};
        vec[1] = '{8'd40,  8'd2, 8'd3, 8'h80, 13, 4, 8'd40,  8'h80};
        vec[2] = '{8'd0,   8'd3, 8'd1, 8'h22, 11, 0, 8'd40,  8'h80};
        vec[3] = '{8'd20,  8'd1, 8'd0, 8'h33,  6, 4, 8'd20,  8'h33};
        vec[4] = '{8'd255, 8'd0, 8'd0, 8'h44,  6, 4, 8'd255, 8'h44};
        vec[5] = '{8'd7,   8'd5, 8'd2, 8'h05, 20, 4, 8'd7,   8'h05};

        // Reset values
        repeat (2) @(negedge clk_i);
        chk("rst_period", period_o, 0);
        chk("rst_pluck", pluck_o, 0);
        chk("rst_dyn", dynamics_o, 0);
        chk("rst_step", step_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Single-step vectors on table entry 0 (vec[0] plays the reset-cleared table)
        for (int v = 0; v < 6; v++) begin
            if (v != 0) wr(3'd0, vec[v].period, vec[v].dur, vec[v].dyn);
            last_step_i = 3'd0; loop_en_i = 1'b0; tempo_i = vec[v].tempo;
            enable_i = 1'b1;
            busy_cyc = 0; pl_cyc = 0; seen = 1'b0;
            for (int c = 0; c < 200 && !seen; c++) begin
                @(negedge clk_i);
                if (busy_o) busy_cyc++;
                if (pluck_o) pl_cyc++;
                if (done_o) begin
                    seen = 1'b1;
                    enable_i = 1'b0;
                    chk($sformatf("v%0d_done_busy", v), busy_o, 0);
                    chk($sformatf("v%0d_period", v), period_o, vec[v].exp_period);
                    chk($sformatf("v%0d_dyn", v), dynamics_o, DYN_EN ? vec[v].exp_dyn : 0);
                end
            end
            chk($sformatf("v%0d_done_seen", v), seen, 1);
            chk($sformatf("v%0d_len", v), busy_cyc, vec[v].exp_len);
            chk($sformatf("v%0d_pluck_cycles", v), pl_cyc, vec[v].exp_plucks);
            enable_i = 1'b0;
            @(negedge clk_i);
            chk($sformatf("v%0d_done_pulse", v), done_o, 0);
            chk($sformatf("v%0d_idle", v), busy_o, 0);
        end

        // Two-step, no loop: {0:(40,2), 1:(20,1)}, tempo 3
        wr(3'd0, 8'd40, 8'd2, 8'h80);
        wr(3'd1, 8'd20, 8'd1, 8'h90);
        last_step_i = 3'd1; loop_en_i = 1'b0; tempo_i = 8'd3;
        capture(23);
        go_idle(3);
        chk("c_load_busy", tr[0].busy, 1);
        chk("c_load_nopluck", tr[0].pluck, 0);
        chk("c_p0_pluck", tr[1].pluck, 1);
        chk("c_p0_period", tr[1].period, 40);
        chk("c_p0_len", pluck_rises(13) == 1 && tr[4].pluck && !tr[5].pluck, 1);
        chk("c_s1_load_step", tr[13].step, 1);
        chk("c_s1_load_nopluck", tr[13].pluck, 0);
        chk("c_s0_hold_step", tr[12].step, 0);
        chk("c_s1_period", tr[14].period, 20);
        chk("c_s1_pluck", tr[14].pluck, 1);
        chk("c_last_hold_busy", tr[21].busy, 1);
        chk("c_last_hold_nodone", tr[21].done, 0);
        chk("c_done", tr[22].done, 1);
        chk("c_done_busy", tr[22].busy, 0);
        chk("c_done_count", done_count(23), 1);

        // Looping: three full loops of 22 cycles
        loop_en_i = 1'b1;
        capture(66);
        go_idle(3);
        chk("d_step_a", tr[0].step, 0);
        chk("d_step_b", tr[13].step, 1);
        chk("d_step_c", tr[22].step, 0);
        chk("d_step_d", tr[35].step, 1);
        chk("d_step_e", tr[44].step, 0);
        chk("d_step_f", tr[57].step, 1);
        chk("d_plucks", pluck_rises(66), 6);
        chk("d_no_done", done_count(66), 0);

        // Abort during step 1's pluck, then restart
        loop_en_i = 1'b0;
        capture(16);
        chk("e_pre_pluck", tr[15].pluck, 1);
        enable_i = 1'b0;
        @(negedge clk_i);
        s = smp();
        chk("e_abort_pluck", s.pluck, 0);
        chk("e_abort_busy", s.busy, 0);
        chk("e_abort_period", s.period, 20);
        dc = s.done;
        repeat (25) begin
            @(negedge clk_i);
            dc += done_o;
        end
        chk("e_abort_no_done", dc, 0);
        capture(2);
        go_idle(3);
        chk("e_restart_step", tr[0].step, 0);
        chk("e_restart_busy", tr[0].busy, 1);
        chk("e_restart_period", tr[1].period, 40);
        chk("e_restart_pluck", tr[1].pluck, 1);

        // Writes while playing: step 0 during its HOLD, step 1 in the same cycle as its LOAD
        loop_en_i = 1'b1;
        enable_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            tr[i] = smp();
            wr_en_i = 1'b0;
            if (i == 6) begin
                wr_en_i = 1'b1; wr_addr_i = 3'd0; wr_period_i = 8'd55; wr_dur_i = 8'd2;
            end
            if (i == 13) begin
                wr_en_i = 1'b1; wr_addr_i = 3'd1; wr_period_i = 8'd99; wr_dur_i = 8'd1;
            end
        end
        go_idle(3);
        chk("f_hold_period", tr[12].period, 40);
        chk("f_same_cycle_old", tr[14].period, 20);
        chk("f_next_loop_s0", tr[23].period, 55);
        chk("f_next_loop_s1", tr[36].period, 99);

        // Asynchronous reset during step 1's pluck
        capture(15);
        chk("g_pre_pluck", tr[14].pluck, 1);
        chk("g_pre_step", tr[14].step, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("g_rst_pluck", pluck_o, 0);
        chk("g_rst_period", period_o, 0);
        chk("g_rst_step", step_o, 0);
        chk("g_rst_busy", busy_o, 0);
        chk("g_rst_dyn", dynamics_o, 0);
        enable_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Table is cleared by reset: rest step, done after 6 cycles
        loop_en_i = 1'b0; last_step_i = 3'd0; tempo_i = 8'd0;
        capture(8);
        go_idle(2);
        chk("h_rest_pluck", pluck_rises(8), 0);
        chk("h_period", tr[6].period, 0);
        chk("h_hold_busy", tr[5].busy, 1);
        chk("h_done", tr[6].done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
